// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request at a time, a single
// holding register toward decode, and sticky alignment/timeout fault flags.
module instr_fetch #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_stall,
    output logic        align_fault,
    output logic        timeout_fault
);

    typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic       pc_ok;
    logic       waiting;
    logic       timed_out;
    logic       accept_pc;
    logic       capture;
    logic       set_align;

    assign pc_ok     = pc_valid && !flush && (pc[1:0] == 2'b00) && !align_fault && !timeout_fault;
    assign waiting   = (state == REQ) || (state == DROP);
    assign timed_out = waiting && !imem_ack && (count == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= 8'd0;
            imem_req      <= 1'b0;
            instr_valid   <= 1'b0;
            align_fault   <= 1'b0;
            timeout_fault <= 1'b0;
            imem_addr     <= 32'd0;
            instr         <= 32'd0;
            instr_pc      <= 32'd0;
        end else begin
            state       <= state_next;
            imem_req    <= (state_next == REQ) || (state_next == DROP);
            instr_valid <= (state_next == HOLD);
            // The wait budget restarts whenever a request or a drop begins.
            if (((state_next == REQ) || (state_next == DROP)) && (state_next != state))
                count <= 8'd0;
            else if (waiting && !imem_ack)
                count <= count + 8'd1;
            if (accept_pc)
                imem_addr <= pc;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
            if (set_align)
                align_fault <= 1'b1;
            if (timed_out)
                timeout_fault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_pc) state_next = REQ;
            REQ: begin
                if (imem_ack)
                    state_next = flush ? IDLE : HOLD;
                else if (timed_out)
                    state_next = IDLE;
                else if (flush)
                    state_next = DROP;
            end
            DROP: if (imem_ack || timed_out) state_next = IDLE;
            HOLD: begin
                if (flush)
                    state_next = IDLE;
                else if (instr_ready)
                    state_next = accept_pc ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_stall  = 1'b0;
        accept_pc = 1'b0;
        capture   = 1'b0;
        set_align = 1'b0;
        case (state)
            IDLE: begin
                accept_pc = pc_ok;
                set_align = pc_valid && (pc[1:0] != 2'b00);
            end
            REQ: begin
                pc_stall = 1'b1;
                capture  = imem_ack && !flush;
            end
            DROP: pc_stall = 1'b1;
            HOLD: begin
                pc_stall  = !instr_ready;
                accept_pc = instr_ready && pc_ok;
                set_align = instr_ready && !flush && pc_valid && (pc[1:0] != 2'b00);
            end
            default: pc_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each row is one clock cycle of inputs plus the
// outputs expected during that cycle, followed by hand-written fault sequences.
module tb_instr_fetch;

    localparam logic [31:0] P  = 32'h0040_0000;
    localparam logic [31:0] D  = 32'h8C08_0004;
    localparam logic [31:0] I0 = 32'h1111_1111;
    localparam logic [31:0] I1 = 32'h2222_2222;
    localparam logic [31:0] I2 = 32'h3333_3333;
    localparam logic [31:0] I3 = 32'hA5A5_A5A5;
    localparam logic [31:0] I4 = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        pcv;
        logic        fl;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        stall;
        logic        af;
        logic        tf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_stall;
    logic        align_fault;
    logic        timeout_fault;

    int vectors_applied = 0;
    int miscompares = 0;
    vec_t vecs[$];

    instr_fetch #(.TIMEOUT(4)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .pc_valid(pc_valid),
        .flush(flush),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_stall(pc_stall),
        .align_fault(align_fault),
        .timeout_fault(timeout_fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic rst, input logic [31:0] vpc, input logic pcv,
                               input logic fl, input logic ack, input logic [31:0] rdata,
                               input logic rdy, input logic req, input logic [31:0] addr,
                               input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                               input logic stall, input logic af, input logic tf);
        vec_t r;
        r.rst = rst; r.pc = vpc; r.pcv = pcv; r.fl = fl; r.ack = ack; r.rdata = rdata;
        r.rdy = rdy; r.req = req; r.addr = addr; r.iv = iv; r.ins = ins; r.ipc = ipc;
        r.stall = stall; r.af = af; r.tf = tf;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic rst, input logic [31:0] vpc, input logic pcv,
                                 input logic fl, input logic ack, input logic [31:0] rdata,
                                 input logic rdy);
        @(negedge clk);
        reset       = rst;
        pc          = vpc;
        pc_valid    = pcv;
        flush       = fl;
        imem_ack    = ack;
        imem_rdata  = rdata;
        instr_ready = rdy;
        #1;
    endtask

    task automatic chk(input string tag, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got 0x%08h, expected 0x%08h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic req, input logic [31:0] addr,
                               input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                               input logic stall, input logic af, input logic tf);
        vectors_applied++;
        chk(tag, "imem_req",      {31'd0, imem_req},      {31'd0, req});
        chk(tag, "imem_addr",     imem_addr,              addr);
        chk(tag, "instr_valid",   {31'd0, instr_valid},   {31'd0, iv});
        chk(tag, "instr",         instr,                  ins);
        chk(tag, "instr_pc",      instr_pc,               ipc);
        chk(tag, "pc_stall",      {31'd0, pc_stall},      {31'd0, stall});
        chk(tag, "align_fault",   {31'd0, align_fault},   {31'd0, af});
        chk(tag, "timeout_fault", {31'd0, timeout_fault}, {31'd0, tf});
    endtask

    initial begin
        //               rst pc        pcv fl ack rdata   rdy  req addr      iv ins  ipc       stall af tf
        // single fetch with immediate ack
        vecs.push_back(v(0, 32'h0,      0, 0, 0, 32'h0,  0,   0, 32'h0,     0, 32'h0, 32'h0,     0, 0, 0));
        vecs.push_back(v(1, P,          1, 0, 0, 32'h0,  1,   0, 32'h0,     0, 32'h0, 32'h0,     0, 0, 0));
        vecs.push_back(v(1, P,          0, 0, 1, D,      1,   1, P,         0, 32'h0, 32'h0,     1, 0, 0));
        vecs.push_back(v(1, P,          0, 0, 0, 32'h0,  1,   0, P,         1, D,     P,         0, 0, 0));
        vecs.push_back(v(1, P,          0, 0, 0, 32'h0,  1,   0, P,         0, D,     P,         0, 0, 0));
        // back-to-back fetch of 0x0, 0x4, 0x8
        vecs.push_back(v(1, 32'h0,      1, 0, 0, 32'h0,  1,   0, P,         0, D,     P,         0, 0, 0));
        vecs.push_back(v(1, 32'h4,      1, 0, 1, I0,     1,   1, 32'h0,     0, D,     P,         1, 0, 0));
        vecs.push_back(v(1, 32'h4,      1, 0, 0, 32'h0,  1,   0, 32'h0,     1, I0,    32'h0,     0, 0, 0));
        vecs.push_back(v(1, 32'h8,      1, 0, 1, I1,     1,   1, 32'h4,     0, I0,    32'h0,     1, 0, 0));
        vecs.push_back(v(1, 32'h8,      1, 0, 0, 32'h0,  1,   0, 32'h4,     1, I1,    32'h4,     0, 0, 0));
        vecs.push_back(v(1, 32'hC,      0, 0, 1, I2,     1,   1, 32'h8,     0, I1,    32'h4,     1, 0, 0));
        vecs.push_back(v(1, 32'hC,      0, 0, 0, 32'h0,  1,   0, 32'h8,     1, I2,    32'h8,     0, 0, 0));
        vecs.push_back(v(1, 32'hC,      0, 0, 0, 32'h0,  1,   0, 32'h8,     0, I2,    32'h8,     0, 0, 0));
        // ack after three waiting cycles, then flush while decode stalls
        vecs.push_back(v(1, 32'h100,    1, 0, 0, 32'h0,  0,   0, 32'h8,     0, I2,    32'h8,     0, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 0, 32'h0,  0,   1, 32'h100,   0, I2,    32'h8,     1, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 0, 32'h0,  0,   1, 32'h100,   0, I2,    32'h8,     1, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 0, 32'h0,  0,   1, 32'h100,   0, I2,    32'h8,     1, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 1, I3,     0,   1, 32'h100,   0, I2,    32'h8,     1, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 0, 32'h0,  0,   0, 32'h100,   1, I3,    32'h100,   1, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 1, 0, 32'h0,  0,   0, 32'h100,   1, I3,    32'h100,   1, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 0, 32'h0,  0,   0, 32'h100,   0, I3,    32'h100,   0, 0, 0));
        vecs.push_back(v(1, 32'h100,    0, 0, 0, 32'h0,  0,   0, 32'h100,   0, I3,    32'h100,   0, 0, 0));
        // flush in the first request cycle; flush in DROP is ignored
        vecs.push_back(v(1, 32'h200,    1, 0, 0, 32'h0,  1,   0, 32'h100,   0, I3,    32'h100,   0, 0, 0));
        vecs.push_back(v(1, 32'h200,    0, 1, 0, 32'h0,  1,   1, 32'h200,   0, I3,    32'h100,   1, 0, 0));
        vecs.push_back(v(1, 32'h200,    0, 1, 0, 32'h0,  1,   1, 32'h200,   0, I3,    32'h100,   1, 0, 0));
        vecs.push_back(v(1, 32'h200,    0, 0, 1, I4,     1,   1, 32'h200,   0, I3,    32'h100,   1, 0, 0));
        vecs.push_back(v(1, 32'h200,    0, 0, 0, 32'h0,  1,   0, 32'h200,   0, I3,    32'h100,   0, 0, 0));
        // flush blocks acceptance in IDLE; a stray ack in IDLE is ignored
        vecs.push_back(v(1, 32'h300,    1, 1, 0, 32'h0,  1,   0, 32'h200,   0, I3,    32'h100,   0, 0, 0));
        vecs.push_back(v(1, 32'h300,    0, 0, 1, 32'hFFFF_FFFF, 1, 0, 32'h200, 0, I3, 32'h100,   0, 0, 0));
        vecs.push_back(v(1, 32'h300,    0, 0, 0, 32'h0,  1,   0, 32'h200,   0, I3,    32'h100,   0, 0, 0));

        $display("[TB] start, %0d table rows", vecs.size());
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].pc, vecs[i].pcv, vecs[i].fl, vecs[i].ack,
                          vecs[i].rdata, vecs[i].rdy);
            checkOutput($sformatf("row%0d", i), vecs[i].req, vecs[i].addr, vecs[i].iv,
                        vecs[i].ins, vecs[i].ipc, vecs[i].stall, vecs[i].af, vecs[i].tf);
        end

        // Reset in a request cycle beats ack/flush/ready; a late ack is then ignored.
        applyStimulus(1, 32'h400, 1, 0, 0, 32'h0, 0);
        checkOutput("rst_req_accept", 0, 32'h200, 0, I3, 32'h100, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 1, 1, 32'h1234_5678, 1);
        checkOutput("rst_req_inreq", 1, 32'h400, 0, I3, 32'h100, 1, 0, 0);
        applyStimulus(1, 32'h0, 0, 0, 1, 32'h1234_5678, 1);
        checkOutput("rst_req_cleared", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(1, 32'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("rst_req_lateack", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);

        // Misaligned pc raises the sticky fault and blocks later fetches.
        applyStimulus(1, 32'h0040_0002, 1, 0, 0, 32'h0, 1);
        checkOutput("align_present", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(1, P, 1, 0, 0, 32'h0, 1);
        checkOutput("align_set", 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(1, P, 1, 0, 0, 32'h0, 1);
        checkOutput("align_blocked", 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("align_prereset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(1, 32'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("align_cleared", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);

        // No ack for four request cycles with TIMEOUT=4.
        applyStimulus(1, 32'h500, 1, 0, 0, 32'h0, 1);
        checkOutput("tmo_accept", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 32'h500, 0, 0, 0, 32'h0, 1);
            checkOutput($sformatf("tmo_wait%0d", k), 1, 32'h500, 0, 32'h0, 32'h0, 1, 0, 0);
        end
        applyStimulus(1, 32'h502, 1, 0, 0, 32'h0, 1);
        checkOutput("tmo_set", 0, 32'h500, 0, 32'h0, 32'h0, 0, 0, 1);
        applyStimulus(1, P, 1, 0, 0, 32'h0, 1);
        checkOutput("tmo_both", 0, 32'h500, 0, 32'h0, 32'h0, 0, 1, 1);
        applyStimulus(1, 32'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("tmo_blocked", 0, 32'h500, 0, 32'h0, 32'h0, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("tmo_prereset", 0, 32'h500, 0, 32'h0, 32'h0, 0, 1, 1);
        applyStimulus(1, 32'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("tmo_cleared", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles to wait for imem_ack; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
REQ-004 pc  input  32  fetch address from the next-PC stage.
REQ-005 pc_valid  input  1  pc holds an address to fetch.
REQ-006 flush  input  1  taken branch or jump; discards the in-flight fetch and any held fetch.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 instr  output  32  fetched instruction, sent to decode.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 instr_valid  output  1  instr and instr_pc are valid.
REQ-014 instr_ready  input  1  decode accepts instr this cycle.
REQ-015 pc_stall  output  1  next-PC stage holds pc.
REQ-016 align_fault  output  1  sticky flag: a misaligned pc was presented.
REQ-017 timeout_fault  output  1  sticky flag: the memory did not respond within TIMEOUT cycles.

Function
REQ-018 FSM states: IDLE, REQ, DROP, HOLD; at most one memory request outstanding at any time.
REQ-019 IDLE transitions:
- pc_valid=1, flush=0, pc[1:0]=00, no fault set: latch imem_addr<=pc; go to REQ.
- pc_valid=1 and pc[1:0]!=00: set align_fault; stay in IDLE.
- imem_ack in IDLE is ignored.
REQ-020 REQ state:
- imem_req=1; imem_addr held stable until ack.
- imem_ack=1 with flush=0: instr<=imem_rdata, instr_pc<=imem_addr; go to HOLD.
- imem_ack=1 with flush=1: discard the data; go to IDLE.
- flush=1 with imem_ack=0: go to DROP.
REQ-021 DROP state:
- imem_req stays 1; the request is never withdrawn before ack.
- imem_ack=1: discard the data; go to IDLE.
- flush is ignored in DROP.
REQ-022 HOLD state:
- instr_valid=1.
- flush=1 (takes priority over instr_ready): go to IDLE; instr_valid=0 from the next cycle.
- instr_ready=1 with pc_valid=1, pc aligned, no fault: latch pc; go directly to REQ (back-to-back fetch).
- instr_ready=1 otherwise: go to IDLE.
- instr_ready=0: hold instr and instr_pc unchanged.
REQ-023 Timeout counter (8-bit):
- cleared on entry to REQ or DROP.
- increments on each REQ or DROP cycle with imem_ack=0.
- reaches TIMEOUT: set timeout_fault; drop imem_req next cycle; go to IDLE.
REQ-024 Once align_fault or timeout_fault is set, no new fetch starts until reset.
REQ-025 pc_stall is combinational:
- 1 in REQ and in DROP.
- 1 in HOLD with instr_ready=0.
- 0 otherwise.
- Acceptance of pc is therefore visible to the next-PC stage in the same cycle.
REQ-026 imem_req, instr_valid, imem_addr, instr and instr_pc are registered outputs.
REQ-027 imem_ack arriving on the same cycle as entry to REQ is impossible, because the request becomes visible only after the edge; minimum fetch latency is pc accepted at edge N, imem_req high in cycle N+1, instr_valid high in cycle N+2 when ack arrives in cycle N+1.

Reset
REQ-028 reset=0 at an edge:
- state<=IDLE; counter<=0.
- imem_req, instr_valid, align_fault, timeout_fault <= 0.
- imem_addr, instr, instr_pc <= 0.
REQ-029 Reset overrides flush, ack and ready in the same cycle.
REQ-030 Reset during REQ drops imem_req at that edge; a late imem_ack afterwards is ignored in IDLE.

Verification
REQ-031 pc=0x00400000, pc_valid=1, ack one cycle after req with rdata=0x8C080004, instr_ready=1 -> instr=0x8C080004, instr_pc=0x00400000, instr_valid high exactly one cycle; pc_stall high during REQ.
REQ-032 Ack delayed 3 cycles, then flush during HOLD with instr_ready=0 -> instr_valid falls at the next edge; no second imem_req until a new pc is accepted.
REQ-033 flush in the first REQ cycle, ack 2 cycles later -> imem_req held through DROP; data discarded; instr_valid never asserts; state IDLE after ack.
REQ-034 pc=0x00400002 -> align_fault=1 the next cycle; imem_req stays 0; a later aligned pc is not fetched until reset.
REQ-035 TIMEOUT=4, no ack -> timeout_fault=1 after 4 REQ cycles; imem_req=0 the next cycle; reset=0 clears both faults and all outputs.
REQ-036 Back-to-back fetch at 0x0, 0x4, 0x8, instr_ready always 1, ack one cycle after req -> one instruction delivered every 2 cycles, in order; no HOLD->IDLE gap.
